// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: command-driven counter built on a bank of toggle flip-flops.
// Accepts one command per start handshake (up N, down N, load value, clear), walks the
// toggle bank through it one step per cycle, and pulses done for one cycle on completion.
// The bank is only ever steered through its T vector; count is never written directly.
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   start    command request, accepted only while busy=0
//   mode     00 up, 01 down, 10 load, 11 clear (sampled with start)
//   operand  step count for up/down, load value for load, ignored for clear
//   busy     high from the cycle after acceptance until return to idle
//   done     one-cycle completion pulse
//   count    registered Q of the toggle bank
//   wrap     sticky flag: count wrapped during the last command
module tff_count_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [1:0] ModeUp    = 2'b00;
  localparam logic [1:0] ModeDown  = 2'b01;
  localparam logic [1:0] ModeLoad  = 2'b10;
  localparam logic [1:0] ModeClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] t_up, t_down, t_sel, t;

  // Ripple-carry/borrow toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic ones, zeros;
    ones   = 1'b1;
    zeros  = 1'b1;
    t_up   = '0;
    t_down = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      t_up[i]   = ones;
      t_down[i] = zeros;
      ones      = ones & count_q[i];
      zeros     = zeros & ~count_q[i];
    end
  end

  always_comb begin
    t_sel = '0;
    unique case (mode_q)
      ModeUp:    t_sel = t_up;
      ModeDown:  t_sel = t_down;
      ModeLoad:  t_sel = count_q ^ operand_q;
      ModeClear: t_sel = count_q;
      default:   t_sel = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    operand_d = operand_q;
    steps_d   = steps_q;
    wrap_d    = wrap_q;
    t         = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          mode_d    = mode;
          operand_d = operand;
          wrap_d    = 1'b0;
          // Load and clear finish in a single toggle step.
          steps_d   = (mode == ModeUp || mode == ModeDown) ? operand : WIDTH'(1);
        end
      end
      StRun: begin
        if (steps_q == '0) begin
          state_d = StDone;
        end else begin
          t       = t_sel;
          steps_d = steps_q - WIDTH'(1);
          if ((mode_q == ModeUp && (&count_q)) || (mode_q == ModeDown && count_q == '0)) begin
            wrap_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      mode_q    <= ModeUp;
      operand_q <= '0;
      steps_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      operand_q <= operand_d;
      steps_q   <= steps_d;
      wrap_q    <= wrap_d;
    end
  end

  // Toggle-flip-flop bank: each bit flips when its T input is set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_q ^ t;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
